// File: rtl/writeback_arbiter_if.sv
// Result-side bus between the functional units and the writeback arbiter, plus the
// completion, wakeup and mispredict broadcasts that the arbiter drives back out.
interface writeback_arbiter_if;
   logic       alu_valid_in;
   logic       br_valid_in;
   logic       lsu_valid_in;
   logic       alu_ready_out;
   logic       br_ready_out;
   logic       lsu_ready_out;
   logic [4:0] alu_rob_tag;
   logic [4:0] br_rob_tag;
   logic [4:0] lsu_rob_tag;
   logic [6:0] alu_prd;
   logic [6:0] br_prd;
   logic [6:0] lsu_prd;
   logic       alu_has_rd;
   logic       br_has_rd;
   logic       lsu_has_rd;
   logic       br_mispredict;
   logic [4:0] rob_head_tag;
   logic       complete_out;
   logic [4:0] rob_fu_tag;
   logic [6:0] preg1_rdy;
   logic [6:0] preg2_rdy;
   logic [6:0] preg3_rdy;
   logic       preg1_valid;
   logic       preg2_valid;
   logic       preg3_valid;
   logic       mispredict;
   logic [4:0] mispredict_tag;

   // Functional-unit / ROB side
   modport master (
      output alu_valid_in, br_valid_in, lsu_valid_in,
      output alu_rob_tag, br_rob_tag, lsu_rob_tag,
      output alu_prd, br_prd, lsu_prd,
      output alu_has_rd, br_has_rd, lsu_has_rd,
      output br_mispredict, rob_head_tag,
      input  alu_ready_out, br_ready_out, lsu_ready_out,
      input  complete_out, rob_fu_tag,
      input  preg1_rdy, preg2_rdy, preg3_rdy,
      input  preg1_valid, preg2_valid, preg3_valid,
      input  mispredict, mispredict_tag
   );

   // Arbiter side
   modport slave (
      input  alu_valid_in, br_valid_in, lsu_valid_in,
      input  alu_rob_tag, br_rob_tag, lsu_rob_tag,
      input  alu_prd, br_prd, lsu_prd,
      input  alu_has_rd, br_has_rd, lsu_has_rd,
      input  br_mispredict, rob_head_tag,
      output alu_ready_out, br_ready_out, lsu_ready_out,
      output complete_out, rob_fu_tag,
      output preg1_rdy, preg2_rdy, preg3_rdy,
      output preg1_valid, preg2_valid, preg3_valid,
      output mispredict, mispredict_tag
   );
endinterface

// File: rtl/writeback_arbiter.sv
// Per-FU result FIFOs feeding a round-robin single-grant completion port, with
// squash of every buffered result younger than a granted mispredicted branch.
module writeback_arbiter #(
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               reset,
   writeback_arbiter_if.slave wb
);
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int NUM_FU = 3;

   typedef enum logic [1:0] {
      FU_ALU = 2'd0,
      FU_BR  = 2'd1,
      FU_LSU = 2'd2
   } fu_e;

   typedef struct packed {
      logic [4:0] tag;
      logic [6:0] prd;
      logic       has_rd;
      logic       mispred;
   } entry_t;

   entry_t            fifo_q   [NUM_FU][DEPTH];
   entry_t            fifo_d   [NUM_FU][DEPTH];
   logic [CNT_W-1:0]  cnt_q    [NUM_FU];
   logic [CNT_W-1:0]  cnt_d    [NUM_FU];
   entry_t            in_entry [NUM_FU];
   fu_e               ptr_q, ptr_d;

   logic [NUM_FU-1:0] valid_in, ready, push, pop, nonempty;
   logic              grant_vld;
   fu_e               grant_fu;
   entry_t            grant_entry;
   logic              squash;

   logic              complete_q;
   logic [4:0]        rob_fu_tag_q;
   logic [6:0]        rdy_q    [NUM_FU];
   logic [NUM_FU-1:0] pvalid_q;
   logic              mispredict_q;
   logic [4:0]        mispredict_tag_q;

   // Ages are measured from the ROB head so that tag wrap-around orders correctly.
   function automatic logic is_younger(input logic [4:0] tag, input logic [4:0] br_tag,
                                       input logic [4:0] head);
      logic [4:0] age_t;
      logic [4:0] age_b;
      age_t = tag - head;
      age_b = br_tag - head;
      return age_t > age_b;
   endfunction

   always_comb begin
      in_entry[0] = '{tag: wb.alu_rob_tag, prd: wb.alu_prd, has_rd: wb.alu_has_rd, mispred: 1'b0};
      in_entry[1] = '{tag: wb.br_rob_tag,  prd: wb.br_prd,  has_rd: wb.br_has_rd,
                      mispred: wb.br_mispredict};
      in_entry[2] = '{tag: wb.lsu_rob_tag, prd: wb.lsu_prd, has_rd: wb.lsu_has_rd, mispred: 1'b0};
      valid_in    = {wb.lsu_valid_in, wb.br_valid_in, wb.alu_valid_in};
      for (int f = 0; f < NUM_FU; f++) begin
         nonempty[f] = (cnt_q[f] != '0);
         ready[f]    = !reset && (cnt_q[f] != CNT_W'(DEPTH));
      end
      push = valid_in & ready;
   end

   assign wb.alu_ready_out = ready[0];
   assign wb.br_ready_out  = ready[1];
   assign wb.lsu_ready_out = ready[2];

   // Only registered occupancy is visible here, so a push into an empty FIFO waits a cycle.
   always_comb begin
      logic [2:0] cand;
      grant_vld = 1'b0;
      grant_fu  = ptr_q;
      cand      = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         cand = {1'b0, ptr_q} + 3'(k);
         if (cand >= 3'd3) cand = cand - 3'd3;
         if (!grant_vld && nonempty[cand[1:0]]) begin
            grant_vld = 1'b1;
            grant_fu  = fu_e'(cand[1:0]);
         end
      end
      grant_entry = fifo_q[grant_fu][0];
      pop         = grant_vld ? (3'b001 << grant_fu) : '0;
      squash      = grant_vld && (grant_fu == FU_BR) && grant_entry.mispred;
      ptr_d       = ptr_q;
      if (grant_vld) ptr_d = (grant_fu == FU_LSU) ? FU_ALU : fu_e'(grant_fu + 2'd1);
   end

   // Next FIFO contents: drop the popped head, append the push, filter squashed
   // entries and compact the survivors towards slot 0 in their original order.
   always_comb begin
      int   n;
      logic keep;
      n    = 0;
      keep = 1'b0;
      for (int f = 0; f < NUM_FU; f++) begin
         // NOTE: every combinational output gets a default before any conditional
         // update; a path that leaves it unassigned would infer a latch.
         fifo_d[f] = fifo_q[f];
         n         = 0;
         for (int i = 0; i < DEPTH; i++) begin
            keep = (i < int'(cnt_q[f])) && !(pop[f] && (i == 0));
            if (squash && is_younger(fifo_q[f][i].tag, grant_entry.tag, wb.rob_head_tag))
               keep = 1'b0;
            if (keep) begin
               fifo_d[f][n[PTR_W-1:0]] = fifo_q[f][i];
               n = n + 1;
            end
         end
         keep = push[f];
         if (squash && is_younger(in_entry[f].tag, grant_entry.tag, wb.rob_head_tag))
            keep = 1'b0;
         if (keep && (n < DEPTH)) begin
            fifo_d[f][n[PTR_W-1:0]] = in_entry[f];
            n = n + 1;
         end
         cnt_d[f] = CNT_W'(n);
      end
   end

   // NOTE: the entry storage carries no reset; occupancy counters alone decide
   // which slots are meaningful, so clearing the payload would only add wiring.
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q            <= '{default: '0};
         ptr_q            <= FU_ALU;
         complete_q       <= 1'b0;
         rob_fu_tag_q     <= '0;
         rdy_q            <= '{default: '0};
         pvalid_q         <= '0;
         mispredict_q     <= 1'b0;
         mispredict_tag_q <= '0;
      end else begin
         cnt_q            <= cnt_d;
         ptr_q            <= ptr_d;
         complete_q       <= grant_vld;
         rob_fu_tag_q     <= grant_vld ? grant_entry.tag : '0;
         for (int f = 0; f < NUM_FU; f++) begin
            rdy_q[f]    <= pop[f] ? grant_entry.prd : '0;
            pvalid_q[f] <= pop[f] && grant_entry.has_rd && (grant_entry.prd != '0);
         end
         mispredict_q     <= squash;
         mispredict_tag_q <= squash ? grant_entry.tag : '0;
      end
   end

   assign wb.complete_out   = complete_q;
   assign wb.rob_fu_tag     = rob_fu_tag_q;
   assign wb.preg1_rdy      = rdy_q[0];
   assign wb.preg2_rdy      = rdy_q[1];
   assign wb.preg3_rdy      = rdy_q[2];
   assign wb.preg1_valid    = pvalid_q[0];
   assign wb.preg2_valid    = pvalid_q[1];
   assign wb.preg3_valid    = pvalid_q[2];
   assign wb.mispredict     = mispredict_q;
   assign wb.mispredict_tag = mispredict_tag_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed scenarios for writeback_arbiter; expected completions are queued when
// results are driven and compared in order as complete_out pulses appear.
module tb_writeback_arbiter;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic reset;
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   mon_en   = 1'b0;

   typedef struct {
      int tag;
      int fu;
      int prd;
      int pv;
      int mp;
      int cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   writeback_arbiter_if wb();

   writeback_arbiter #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .wb    (wb.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_done(input int tag, input int fu, input int prd, input int pv,
                              input int mp, input int at_cyc);
      exp_t e;
      e.tag = tag; e.fu = fu; e.prd = prd; e.pv = pv; e.mp = mp; e.cyc = at_cyc;
      sb.push_back(e);
   endtask

   task automatic drive_alu(input logic v, input int tag, input int prd, input logic has_rd);
      wb.alu_valid_in = v;
      wb.alu_rob_tag  = 5'(tag);
      wb.alu_prd      = 7'(prd);
      wb.alu_has_rd   = has_rd;
   endtask

   task automatic drive_br(input logic v, input int tag, input int prd, input logic has_rd,
                           input logic mp);
      wb.br_valid_in   = v;
      wb.br_rob_tag    = 5'(tag);
      wb.br_prd        = 7'(prd);
      wb.br_has_rd     = has_rd;
      wb.br_mispredict = mp;
   endtask

   task automatic drive_lsu(input logic v, input int tag, input int prd, input logic has_rd);
      wb.lsu_valid_in = v;
      wb.lsu_rob_tag  = 5'(tag);
      wb.lsu_prd      = 7'(prd);
      wb.lsu_has_rd   = has_rd;
   endtask

   task automatic clear_inputs();
      drive_alu(1'b0, 0, 0, 1'b0);
      drive_br(1'b0, 0, 0, 1'b0, 1'b0);
      drive_lsu(1'b0, 0, 0, 1'b0);
   endtask

   // Wait (bounded) for all queued completions, then idle a few cycles for strays.
   task automatic drain(input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) tick();
      check("drain_pending", 32'(sb.size()), 32'd0);
      repeat (3) tick();
   endtask

   // Output monitor: sampled 1 time unit after each rising edge.
   always begin
      @(posedge clk);
      #1;
      if (mon_en) begin
         if (wb.complete_out !== 1'b0) begin
            if (sb.size() == 0) begin
               check($sformatf("spurious_complete_tag%0d", wb.rob_fu_tag),
                     32'(wb.complete_out), 32'd0);
            end else begin
               mon_e = sb.pop_front();
               check($sformatf("t%0d_rob_fu_tag", mon_e.tag), 32'(wb.rob_fu_tag), mon_e.tag);
               check($sformatf("t%0d_preg1_rdy", mon_e.tag), 32'(wb.preg1_rdy),
                     (mon_e.fu == 1) ? mon_e.prd : 0);
               check($sformatf("t%0d_preg1_valid", mon_e.tag), 32'(wb.preg1_valid),
                     (mon_e.fu == 1) ? mon_e.pv : 0);
               check($sformatf("t%0d_preg2_rdy", mon_e.tag), 32'(wb.preg2_rdy),
                     (mon_e.fu == 2) ? mon_e.prd : 0);
               check($sformatf("t%0d_preg2_valid", mon_e.tag), 32'(wb.preg2_valid),
                     (mon_e.fu == 2) ? mon_e.pv : 0);
               check($sformatf("t%0d_preg3_rdy", mon_e.tag), 32'(wb.preg3_rdy),
                     (mon_e.fu == 3) ? mon_e.prd : 0);
               check($sformatf("t%0d_preg3_valid", mon_e.tag), 32'(wb.preg3_valid),
                     (mon_e.fu == 3) ? mon_e.pv : 0);
               check($sformatf("t%0d_mispredict", mon_e.tag), 32'(wb.mispredict), mon_e.mp);
               check($sformatf("t%0d_mispredict_tag", mon_e.tag), 32'(wb.mispredict_tag),
                     (mon_e.mp != 0) ? mon_e.tag : 0);
               if (mon_e.cyc >= 0)
                  check($sformatf("t%0d_cycle", mon_e.tag), 32'(cyc), mon_e.cyc);
            end
         end else begin
            check("idle_outputs",
                  32'({wb.mispredict, wb.preg1_valid, wb.preg2_valid, wb.preg3_valid,
                       wb.mispredict_tag, wb.rob_fu_tag}), 32'd0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $fatal(1, "simulation time limit");
   end

   initial begin
      int c;
      reset           = 1'b1;
      wb.rob_head_tag = 5'd0;
      clear_inputs();

      // Reset held for three cycles
      repeat (3) tick();
      check("reset_ready_outs",
            32'({wb.alu_ready_out, wb.br_ready_out, wb.lsu_ready_out}), 32'd0);
      check("reset_outputs",
            32'({wb.complete_out, wb.mispredict, wb.preg1_valid, wb.preg2_valid,
                 wb.preg3_valid, wb.rob_fu_tag, wb.mispredict_tag}), 32'd0);
      reset = 1'b0;
      #1;
      check("post_reset_ready_outs",
            32'({wb.alu_ready_out, wb.br_ready_out, wb.lsu_ready_out}), 32'b111);
      mon_en = 1'b1;

      // All three FUs at once: ALU, BR, LSU on consecutive cycles
      c = cyc;
      drive_alu(1'b1, 1, 'h11, 1'b1);
      drive_br(1'b1, 2, 'h12, 1'b1, 1'b0);
      drive_lsu(1'b1, 3, 'h13, 1'b1);
      expect_done(1, 1, 'h11, 1, 0, c + 2);
      expect_done(2, 2, 'h12, 1, 0, c + 3);
      expect_done(3, 3, 'h13, 1, 0, c + 4);
      tick();
      clear_inputs();
      drain(20);

      // Second simultaneous set starts at ALU again
      c = cyc;
      drive_alu(1'b1, 4, 'h04, 1'b0);
      drive_br(1'b1, 6, 'h46, 1'b1, 1'b0);
      drive_lsu(1'b1, 7, 'h7f, 1'b1);
      expect_done(4, 1, 'h04, 0, 0, c + 2);
      expect_done(6, 2, 'h46, 1, 0, c + 3);
      expect_done(7, 3, 'h7f, 1, 0, c + 4);
      tick();
      clear_inputs();
      drain(20);

      // Single ALU result, minimum latency
      c = cyc;
      drive_alu(1'b1, 5, 'h21, 1'b1);
      expect_done(5, 1, 'h21, 1, 0, c + 2);
      tick();
      clear_inputs();
      drain(20);

      // LSU results that must not wake anything: prd == 0, then has_rd == 0
      c = cyc;
      drive_lsu(1'b1, 8, 'h00, 1'b1);
      expect_done(8, 3, 'h00, 0, 0, c + 2);
      tick();
      drive_lsu(1'b1, 9, 'h10, 1'b0);
      expect_done(9, 3, 'h10, 0, 0, c + 3);
      tick();
      clear_inputs();
      drain(20);

      // Mispredict across the tag wrap: head 30, branch tag 0
      wb.rob_head_tag = 5'd30;
      c = cyc;
      drive_alu(1'b1, 31, 'h31, 1'b1);
      drive_br(1'b1, 0, 'h05, 1'b0, 1'b1);
      expect_done(31, 1, 'h31, 1, 0, c + 2);
      expect_done(0, 2, 'h05, 0, 1, c + 3);
      tick();
      drive_alu(1'b1, 2, 'h22, 1'b1);
      drive_br(1'b0, 0, 0, 1'b0, 1'b0);
      drive_lsu(1'b1, 1, 'h2a, 1'b1);
      tick();
      // Accepted in the squash cycle: tag 3 is younger (dropped), tag 30 older (kept)
      drive_alu(1'b1, 30, 'h30, 1'b1);
      drive_lsu(1'b1, 3, 'h33, 1'b1);
      expect_done(30, 1, 'h30, 1, 0, c + 4);
      tick();
      clear_inputs();
      drain(20);
      wb.rob_head_tag = 5'd0;

      // Fill the ALU FIFO behind BR/LSU traffic; an extra ALU result is refused
      c = cyc;
      drive_alu(1'b1, 10, 'h0a, 1'b1);
      drive_br(1'b1, 12, 'h0c, 1'b1, 1'b0);
      drive_lsu(1'b1, 14, 'h0e, 1'b1);
      expect_done(12, 2, 'h0c, 1, 0, c + 2);
      expect_done(14, 3, 'h0e, 1, 0, c + 3);
      expect_done(10, 1, 'h0a, 1, 0, c + 4);
      expect_done(13, 2, 'h0d, 1, 0, c + 5);
      expect_done(15, 3, 'h0f, 1, 0, c + 6);
      expect_done(11, 1, 'h0b, 1, 0, c + 7);
      tick();
      drive_alu(1'b1, 11, 'h0b, 1'b1);
      drive_br(1'b1, 13, 'h0d, 1'b1, 1'b0);
      drive_lsu(1'b1, 15, 'h0f, 1'b1);
      tick();
      check("alu_ready_when_full", 32'(wb.alu_ready_out), 32'd0);
      clear_inputs();
      drive_alu(1'b1, 20, 'h14, 1'b1);
      tick();
      check("alu_ready_full_with_pop", 32'(wb.alu_ready_out), 32'd0);
      tick();
      check("alu_ready_after_pop", 32'(wb.alu_ready_out), 32'd1);
      clear_inputs();
      drain(30);

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
